// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
//   Synchronises and debounces a raw keypad vector, encodes the accepted key to a
//   binary code and emits a one-cycle strobe per accepted press. Also reports
//   multi-key presses and hold status.
//   Optional feature: define KEY_REPEAT_EN to enable auto-repeat strobes while a
//   single key stays held (REPEAT_DELAY / REPEAT_PERIOD).
module keypad_debounce_encoder #(
    parameter int unsigned NUM_KEYS        = 13,
    parameter int unsigned CODE_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [CODE_W-1:0]   keycode,
    output logic                keystrobe,
    output logic                key_held,
    output logic                multi_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (NUM_KEYS < 2 || NUM_KEYS > (2**CODE_W) - 1 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_debounce_encoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [NUM_KEYS-1:0] pressed_q, pressed_d;
    logic [CODE_W-1:0]   keycode_q, keycode_d;
    logic                multi_q, multi_d;
    logic                held_q;
    logic                load;
    state_e              state_q, state_d;

    // All-ones for more than one key, otherwise the index of the single set bit.
    function automatic logic [CODE_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        if ($countones(v) > 1) begin
            idx = '1;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (v[i]) idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // Debounce: a candidate vector is accepted once seen DEBOUNCE_CYCLES times in a row.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Compare against the next count so acceptance lands in the same edge as the last sample.
        if (cnt_d == CNT_MAX && cand_d != stable_q) begin
            stable_d = cand_d;
        end
    end

    // Press FSM next state; code and vector are captured on every entry to PRESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (stable_q != '0) state_d = S_PRESS;
            end
            S_PRESS, S_HELD: begin
                if (stable_q == '0)             state_d = S_IDLE;
                else if (stable_q != pressed_q) state_d = S_PRESS;
                else                            state_d = S_HELD;
            end
            default: state_d = S_IDLE;
        endcase
        load      = (state_d == S_PRESS);
        pressed_d = load ? stable_q : pressed_q;
        keycode_d = load ? encode(stable_q) : keycode_q;
        multi_d   = load ? ($countones(stable_q) > 1) : multi_q;
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_TOP + 1);
    localparam logic [RPT_W-1:0] RPT_MAX   = RPT_W'(RPT_TOP);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_seen_q, rpt_seen_d;
    logic             rpt_tick;

    // Repeat timer: counts cycles since PRESS (or since the last repeat); a tick is
    // suppressed whenever the FSM is leaving HELD so a new press wins.
    always_comb begin
        rpt_d      = rpt_q;
        rpt_seen_d = rpt_seen_q;
        rpt_tick   = 1'b0;
        if (state_q != S_IDLE && rpt_q != RPT_MAX) rpt_d = rpt_q + 1'b1;
        if (state_q == S_HELD && state_d == S_HELD && !multi_q &&
            rpt_q == (rpt_seen_q ? RPT_NEXT : RPT_FIRST)) begin
            rpt_tick   = 1'b1;
            rpt_d      = RPT_W'(1);
            rpt_seen_d = 1'b1;
        end
        if (load) begin
            rpt_d      = '0;
            rpt_seen_d = 1'b0;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rpt_q      <= '0;
            rpt_seen_q <= 1'b0;
        end else begin
            rpt_q      <= rpt_d;
            rpt_seen_q <= rpt_seen_d;
        end
    end

    assign keystrobe = (state_q == S_PRESS) | rpt_tick;
`else
    assign keystrobe = (state_q == S_PRESS);
`endif

    // Synchroniser, debounce, FSM and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            pressed_q <= '0;
            keycode_q <= '0;
            multi_q   <= 1'b0;
            held_q    <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            sync1_q   <= keypad;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            pressed_q <= pressed_d;
            keycode_q <= keycode_d;
            multi_q   <= multi_d;
            held_q    <= (stable_q != '0);
            state_q   <= state_d;
        end
    end

    assign keycode     = keycode_q;
    assign multi_press = multi_q;
    assign key_held    = held_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Testbench for keypad_debounce_encoder (default build, KEY_REPEAT_EN undefined).
// Reference model: the accepted vector becomes the raw value once DEBOUNCE_CYCLES
// consecutive raw samples agree (offset by the 2-flop synchroniser); outputs follow
// one edge later, a strobe fires whenever the accepted vector changes to non-zero.
module tb_keypad_debounce_encoder;

    localparam int NK = 13;
    localparam int CW = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [NK-1:0] keypad = 13'h1;
    logic [CW-1:0] keycode;
    logic          keystrobe;
    logic          key_held;
    logic          multi_press;

    keypad_debounce_encoder #(
        .NUM_KEYS(NK),
        .CODE_W(CW),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(16),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .keypad(keypad),
        .keycode(keycode),
        .keystrobe(keystrobe),
        .key_held(key_held),
        .multi_press(multi_press)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int strobes = 0;

    logic [NK-1:0] hist[$];
    logic [NK-1:0] st0;      // accepted vector after the latest edge
    logic [NK-1:0] st1;      // accepted vector one edge earlier
    logic [CW-1:0] e_code;
    logic          e_mp;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [CW-1:0] ref_code(input logic [NK-1:0] v);
        if ($countones(v) > 1) return 4'hF;
        return CW'($clog2(v));
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (DB + 2) hist.push_back('0);
        st0    = '0;
        st1    = '0;
        e_code = '0;
        e_mp   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_code"}, 16'(keycode), 16'h0);
        check({tag, "_strobe"}, 16'(keystrobe), 16'h0);
        check({tag, "_held"}, 16'(key_held), 16'h0);
        check({tag, "_multi"}, 16'(multi_press), 16'h0);
    endtask

    // One clock with keypad=kp, then compare all outputs with the model.
    task automatic tick(input logic [NK-1:0] kp);
        logic          exp_strobe;
        logic          exp_held;
        logic          all_eq;
        int            n;
        keypad = kp;
        @(posedge clk);
        hist.push_back(kp);
        exp_strobe = (st0 != '0) && (st0 != st1);
        exp_held   = (st0 != '0);
        if (exp_strobe) begin
            e_code = ref_code(st0);
            e_mp   = ($countones(st0) > 1);
        end
        n      = hist.size();
        all_eq = 1'b1;
        for (int i = n - DB - 2; i < n - 2; i++) begin
            if (hist[i] != hist[n-3]) all_eq = 1'b0;
        end
        st1 = st0;
        if (all_eq) st0 = hist[n-3];
        if (hist.size() > 16) void'(hist.pop_front());
        #1;
        check("keystrobe", 16'(keystrobe), 16'(exp_strobe));
        check("key_held", 16'(key_held), 16'(exp_held));
        check("keycode", 16'(keycode), 16'(e_code));
        check("multi_press", 16'(multi_press), 16'(e_mp));
        if (keystrobe) strobes++;
    endtask

    task automatic hold(input logic [NK-1:0] kp, input int cycles);
        for (int i = 0; i < cycles; i++) tick(kp);
    endtask

    initial begin
        logic [NK-1:0] v;
        int            dur;

        // Reset with a key already down: everything reads zero.
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        nrst = 1'b1;
        model_reset();
        hold(13'h1, 10);
        hold(13'h0, 12);

        // Single key: strobe on the 7th edge, code 5; release keeps the code.
        strobes = 0;
        hold(13'h0020, 6);
        check("k5_early", 16'(strobes), 16'd0);
        tick(13'h0020);
        check("k5_latency", 16'(keystrobe), 16'h1);
        hold(13'h0020, 5);
        check("k5_strobes", 16'(strobes), 16'd1);
        check("k5_code", 16'(keycode), 16'h5);
        check("k5_held", 16'(key_held), 16'h1);
        hold(13'h0, 6);
        check("rel_held_early", 16'(key_held), 16'h1);
        tick(13'h0);
        check("rel_held", 16'(key_held), 16'h0);
        hold(13'h0, 5);
        check("rel_strobes", 16'(strobes), 16'd1);
        check("rel_code", 16'(keycode), 16'h5);

        // Short bounce never gets accepted.
        strobes = 0;
        hold(13'h1000, 2);
        hold(13'h0, 12);
        check("bounce_strobes", 16'(strobes), 16'd0);
        check("bounce_held", 16'(key_held), 16'h0);

        // Two keys, then one of them released.
        strobes = 0;
        hold(13'h0003, 12);
        check("multi_strobes", 16'(strobes), 16'd1);
        check("multi_code", 16'(keycode), 16'hF);
        check("multi_flag", 16'(multi_press), 16'h1);
        hold(13'h0002, 12);
        check("single_strobes", 16'(strobes), 16'd2);
        check("single_code", 16'(keycode), 16'h1);
        check("single_flag", 16'(multi_press), 16'h0);
        hold(13'h0, 12);

        // Long hold: exactly one strobe without auto-repeat.
        strobes = 0;
        hold(13'h0400, 60);
        check("long_strobes", 16'(strobes), 16'd1);
        check("long_code", 16'(keycode), 16'hA);
        hold(13'h0, 12);

        // Reset in the middle of a hold, then a fresh press.
        hold(13'h0008, 10);
        nrst = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_zero("midrst_hold");
        nrst = 1'b1;
        model_reset();
        strobes = 0;
        hold(13'h0008, 6);
        check("midrst_early", 16'(strobes), 16'd0);
        tick(13'h0008);
        check("midrst_latency", 16'(keystrobe), 16'h1);
        hold(13'h0008, 4);
        check("midrst_strobes", 16'(strobes), 16'd1);
        check("midrst_code", 16'(keycode), 16'h3);
        hold(13'h0, 12);

        // Randomised segments checked cycle by cycle against the model.
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 3))
                0: v = '0;
                1: v = NK'(1) << $urandom_range(0, NK - 1);
                2: v = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
                default: v = NK'($urandom);
            endcase
            dur = int'($urandom_range(1, 10));
            hold(v, dur);
        end
        hold(13'h0, 12);
        check("final_held", 16'(key_held), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
